// File: rtl/entropy_bitstream_packer.sv
// Packs right-aligned variable-length codewords into a continuous MSB-first word stream.
// Define PACKER_BITCOUNT_EN to add the per-segment total_bits counter output.
module entropy_bitstream_packer #(
    parameter int unsigned CW_W  = 24,
    parameter int unsigned LEN_W = 6,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cw_valid,
    output logic             cw_ready,
    input  logic [CW_W-1:0]  cw_data,
    input  logic [LEN_W-1:0] cw_len,
    input  logic             flush,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [OUT_W-1:0] word_data,
    output logic             word_last,
    output logic             flush_done,
`ifdef PACKER_BITCOUNT_EN
    output logic             busy,
    output logic [31:0]      total_bits
`else
    output logic             busy
`endif
);

    localparam int unsigned ACC_W  = CW_W + OUT_W;
    localparam int unsigned FILL_W = $clog2(ACC_W + 1);
    localparam int unsigned SH_W   = FILL_W + 1;

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               cw_ready_q, cw_ready_d;
    logic               word_valid_q, word_valid_d;
    logic [OUT_W-1:0]   word_data_q, word_data_d;
    logic               word_last_q, word_last_d;
    logic               flush_done_q, flush_done_d;
    logic               busy_q, busy_d;

    logic [LEN_W-1:0]   len_c;
    logic [CW_W-1:0]    data_m;
    logic               accept;
    logic               word_fire;
    logic               hold;
    logic [SH_W-1:0]    sh;

    // Clamp the length and clear any bits above it.
    assign len_c     = (cw_len > LEN_W'(CW_W)) ? LEN_W'(CW_W) : cw_len;
    assign data_m    = cw_data & ~({CW_W{1'b1}} << len_c);
    assign accept    = cw_valid && cw_ready_q;
    assign word_fire = word_valid_q && word_ready;
    assign hold      = word_valid_q && !word_ready;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        sh           = '0;
        cw_ready_d   = 1'b0;
        word_valid_d = 1'b0;
        word_data_d  = '0;
        word_last_d  = 1'b0;
        flush_done_d = 1'b0;
        busy_d       = 1'b0;

        // Emitted word leaves first; the final padded word empties everything.
        if (word_fire) begin
            if (word_last_q) begin
                acc_d  = '0;
                fill_d = '0;
            end else begin
                acc_d  = acc_q << OUT_W;
                fill_d = fill_q - FILL_W'(OUT_W);
            end
        end

        // Append the new codeword directly below the remaining bits.
        if (accept) begin
            sh     = SH_W'(ACC_W) - SH_W'(fill_d) - SH_W'(len_c);
            acc_d  = acc_d | (ACC_W'(data_m) << sh);
            fill_d = fill_d + FILL_W'(len_c);
        end

        case (state_q)
            ST_RUN:   if (flush) state_d = ST_FLUSH;
            ST_FLUSH: if (fill_d == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        cw_ready_d   = (state_d == ST_RUN) && (fill_d <= FILL_W'(OUT_W));
        word_valid_d = (fill_d >= FILL_W'(OUT_W)) || ((state_d == ST_FLUSH) && (fill_d != '0));
        word_data_d  = acc_d[ACC_W-1 -: OUT_W];
        // A stalled word keeps its last flag even if a flush arrives meanwhile.
        word_last_d  = hold ? word_last_q
                            : ((state_d == ST_FLUSH) && (fill_d != '0) && (fill_d <= FILL_W'(OUT_W)));
        flush_done_d = (state_d == ST_DONE);
        busy_d       = (fill_d != '0) || (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            acc_q        <= '0;
            fill_q       <= '0;
            cw_ready_q   <= 1'b1;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_last_q  <= 1'b0;
            flush_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            cw_ready_q   <= cw_ready_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            word_last_q  <= word_last_d;
            flush_done_q <= flush_done_d;
            busy_q       <= busy_d;
        end
    end

    assign cw_ready   = cw_ready_q;
    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign word_last  = word_last_q;
    assign flush_done = flush_done_q;
    assign busy       = busy_q;

`ifdef PACKER_BITCOUNT_EN
    logic [31:0] total_q, total_d;

    // Segment bit count, shown during flush_done and cleared right after.
    always_comb begin
        total_d = total_q;
        if (flush_done_q) begin
            total_d = '0;
        end else if (accept) begin
            total_d = total_q + 32'(len_c);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign total_bits = total_q;
`endif

endmodule

// File: tb/tb_entropy_bitstream_packer.sv
// Directed self-checking bench for entropy_bitstream_packer.
// Build with PACKER_BITCOUNT_EN defined to also check total_bits.
module tb_entropy_bitstream_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cw_valid;
    logic        cw_ready;
    logic [23:0] cw_data;
    logic [5:0]  cw_len;
    logic        flush;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic        word_last;
    logic        flush_done;
    logic        busy;
`ifdef PACKER_BITCOUNT_EN
    logic [31:0] total_bits;
`endif

    int errors = 0;
    int checks = 0;
    logic [32:0] mon_q[$];

    always #5 clk = ~clk;

    entropy_bitstream_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cw_valid   (cw_valid),
        .cw_ready   (cw_ready),
        .cw_data    (cw_data),
        .cw_len     (cw_len),
        .flush      (flush),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_last  (word_last),
        .flush_done (flush_done),
`ifdef PACKER_BITCOUNT_EN
        .busy       (busy),
        .total_bits (total_bits)
`else
        .busy       (busy)
`endif
    );

    // Record every word handshake that the next rising edge will complete.
    always @(negedge clk) begin
        if (reset_n && word_valid && word_ready) mon_q.push_back({word_last, word_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cw(input logic [23:0] d, input logic [5:0] l);
        int n;
        cw_valid = 1'b1;
        cw_data  = d;
        cw_len   = l;
        n = 0;
        while (!cw_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!cw_ready) begin
            errors++;
            $display("FAIL send_cw_timeout: cw_ready=%b required 1", cw_ready);
        end
        tick();
        cw_valid = 1'b0;
        cw_data  = '0;
        cw_len   = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cw_valid   = 1'($urandom);
            cw_data    = 24'($urandom);
            cw_len     = 6'($urandom);
            flush      = 1'($urandom);
            word_ready = 1'($urandom);
            tick();
            checks++;
            if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %b want 0", word_valid); end
            checks++;
            if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        end
        cw_valid = 1'b0; cw_data = '0; cw_len = '0; flush = 1'b0; word_ready = 1'b1;
        reset_n = 1'b1;
        tick();
        checks++;
        if (cw_ready !== 1'b1) begin errors++; $display("FAIL reset_cw_ready: got %b want 1", cw_ready); end
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b want 0", word_valid); end
`ifdef PACKER_BITCOUNT_EN
        checks++;
        if (total_bits !== 32'd0) begin errors++; $display("FAIL reset_total_bits: got %0d want 0", total_bits); end
`endif
    endtask

    task automatic test_reset_mid();
        word_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_cw(24'hA, 6'd4);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
        reset_n = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy_async: got %b want 0", busy); end
        tick();
        reset_n = 1'b1;
        word_ready = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || word_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_discard: busy=%b word_valid=%b want 0 0", busy, word_valid);
        end
    endtask

    task automatic test_full_word();
        word_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_cw(24'hA, 6'd4);
        checks++;
        if (word_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", word_valid); end
        checks++;
        if (word_data !== 32'hAAAAAAAA) begin errors++; $display("FAIL full_data: got %h want aaaaaaaa", word_data); end
        checks++;
        if (word_last !== 1'b0) begin errors++; $display("FAIL full_last: got %b want 0", word_last); end
        tick();
        checks++;
        if (word_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL full_drained: word_valid=%b busy=%b want 0 0", word_valid, busy);
        end
    endtask

    task automatic test_straddle_flush();
        word_ready = 1'b1;
        send_cw(24'hFFFFFF, 6'd24);
        send_cw(24'h001234, 6'd16);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 32'hFFFFFF12 || word_last !== 1'b0) begin
            errors++;
            $display("FAIL straddle_word: valid=%b data=%h last=%b want 1 ffffff12 0", word_valid, word_data, word_last);
        end
        flush = 1'b1;
        tick();
        checks++;
        if (word_valid !== 1'b1 || word_data !== 32'h34000000 || word_last !== 1'b1) begin
            errors++;
            $display("FAIL straddle_last: valid=%b data=%h last=%b want 1 34000000 1", word_valid, word_data, word_last);
        end
        checks++;
        if (cw_ready !== 1'b0) begin errors++; $display("FAIL straddle_flush_ready: got %b want 0", cw_ready); end
        tick();
        flush = 1'b0;
        checks++;
        if (flush_done !== 1'b1 || word_valid !== 1'b0) begin
            errors++; $display("FAIL straddle_done: flush_done=%b word_valid=%b want 1 0", flush_done, word_valid);
        end
`ifdef PACKER_BITCOUNT_EN
        checks++;
        if (total_bits !== 32'd40) begin errors++; $display("FAIL straddle_total: got %0d want 40", total_bits); end
`endif
        tick();
        checks++;
        if (flush_done !== 1'b0 || cw_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL straddle_run: flush_done=%b cw_ready=%b busy=%b want 0 1 0", flush_done, cw_ready, busy);
        end
`ifdef PACKER_BITCOUNT_EN
        checks++;
        if (total_bits !== 32'd0) begin errors++; $display("FAIL straddle_total_clear: got %0d want 0", total_bits); end
`endif
    endtask

    task automatic test_backpressure();
        word_ready = 1'b0;
        send_cw(24'hFFFFFF, 6'd24);
        checks++;
        if (cw_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_first: got %b want 1", cw_ready); end
        send_cw(24'hFFFFFF, 6'd24);
        checks++;
        if (cw_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", cw_ready); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (word_valid !== 1'b1 || word_data !== 32'hFFFFFFFF || word_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: valid=%b data=%h last=%b want 1 ffffffff 0", word_valid, word_data, word_last);
            end
            tick();
        end
        word_ready = 1'b1;
        tick();
        checks++;
        if (word_valid !== 1'b0 || cw_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: word_valid=%b cw_ready=%b want 0 1", word_valid, cw_ready);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (word_valid !== 1'b1 || word_data !== 32'hFFFF0000 || word_last !== 1'b1) begin
            errors++;
            $display("FAIL bp_last: valid=%b data=%h last=%b want 1 ffff0000 1", word_valid, word_data, word_last);
        end
        tick();
        checks++;
        if (flush_done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", flush_done); end
`ifdef PACKER_BITCOUNT_EN
        checks++;
        if (total_bits !== 32'd48) begin errors++; $display("FAIL bp_total: got %0d want 48", total_bits); end
`endif
        tick();
    endtask

    task automatic test_empty_flush();
        word_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        cw_valid = 1'b1; cw_data = 24'hFF; cw_len = 6'd8;
        checks++;
        if (word_valid !== 1'b0 || cw_ready !== 1'b0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL empty_flush_state: valid=%b cw_ready=%b done=%b want 0 0 0", word_valid, cw_ready, flush_done);
        end
        tick();
        checks++;
        if (flush_done !== 1'b1 || word_valid !== 1'b0 || cw_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: done=%b valid=%b cw_ready=%b want 1 0 0", flush_done, word_valid, cw_ready);
        end
        tick();
        cw_valid = 1'b0; cw_data = '0; cw_len = '0;
        checks++;
        if (flush_done !== 1'b0 || cw_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_run: done=%b cw_ready=%b busy=%b want 0 1 0", flush_done, cw_ready, busy);
        end
    endtask

    task automatic test_mask_clamp();
        word_ready = 1'b1;
        send_cw(24'hFFFFFF, 6'd3);
        send_cw(24'h000000, 6'd29);
        checks++;
        if (word_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL mask_partial: valid=%b busy=%b want 0 1", word_valid, busy);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (word_valid !== 1'b1 || word_data !== 32'hE0000000 || word_last !== 1'b1) begin
            errors++;
            $display("FAIL mask_word: valid=%b data=%h last=%b want 1 e0000000 1", word_valid, word_data, word_last);
        end
        tick();
        checks++;
        if (flush_done !== 1'b1) begin errors++; $display("FAIL mask_done: got %b want 1", flush_done); end
`ifdef PACKER_BITCOUNT_EN
        checks++;
        if (total_bits !== 32'd27) begin errors++; $display("FAIL mask_total: got %0d want 27", total_bits); end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp_w [5];
        int n;
        exp_w[0] = {1'b0, 32'hABCDEFAB};
        exp_w[1] = {1'b0, 32'hCDEFABCD};
        exp_w[2] = {1'b0, 32'hEFABCDEF};
        exp_w[3] = {1'b0, 32'hABCDEFAB};
        exp_w[4] = {1'b1, 32'hCDEF0000};
        mon_q.delete();
        word_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_cw(24'hABCDEF, 6'd24);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        while (!flush_done && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (flush_done !== 1'b1) begin errors++; $display("FAIL b2b_done_timeout: flush_done=%b want 1", flush_done); end
`ifdef PACKER_BITCOUNT_EN
        checks++;
        if (total_bits !== 32'd144) begin errors++; $display("FAIL b2b_total: got %0d want 144", total_bits); end
`endif
        checks++;
        if (mon_q.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d words want 5", mon_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < mon_q.size()) begin
                checks++;
                if (mon_q[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got last=%b data=%h want last=%b data=%h",
                             i, mon_q[i][32], mon_q[i][31:0], exp_w[i][32], exp_w[i][31:0]);
                end
            end
        end
        tick();
    endtask

    initial begin
        reset_n = 1'b0; cw_valid = 1'b0; cw_data = '0; cw_len = '0; flush = 1'b0; word_ready = 1'b0;
        test_reset();
        test_reset_mid();
        test_full_word();
        test_straddle_flush();
        test_backpressure();
        test_empty_flush();
        test_mask_clamp();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
